pwm_duty_scheduler: RTL and testbench

Controller for the PWM datapath: owns the PWM period counter and the active duty register, and arbitrates duty-change requests from the debounced push-button pulses and a host write port. Duty changes are staged in a target register and applied only at a period boundary, so no PWM period is ever truncated or glitched. It sits between the button debounce logic and the `uo_out` PWM pin inside the top-level user module.

---
 rtl/pwm_duty_scheduler.sv | 101 ++++++++++
 tb/tb_pwm_duty_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : pwm_duty_scheduler                                               |
// | Purpose : PWM period counter + active duty register; button/host duty      |
// |           requests are staged and applied only at period boundaries.       |
// |           Define PWM_SLEW_EN to ramp active duty one step per period.      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pwm_duty_scheduler #(
  parameter int PERIOD    = 10,
  parameter int INIT_DUTY = 5,
  localparam int DUTY_W   = $clog2(PERIOD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_pulse,
  input  logic              dec_pulse,
  input  logic              wr_valid,
  input  logic [DUTY_W-1:0] wr_duty,
  output logic              wr_ready,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty_active,
  output logic [DUTY_W-1:0] duty_target,
  output logic              period_end,
  output logic              busy
);

  localparam logic [DUTY_W-1:0] c_PERIOD = DUTY_W'(PERIOD);
  localparam logic [DUTY_W-1:0] c_LAST   = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] c_INIT   = DUTY_W'(INIT_DUTY);
  localparam logic [DUTY_W-1:0] c_ONE    = DUTY_W'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0] active_q, active_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic              wr_accept;

  assign period_end  = (cnt_q == c_LAST);
  assign pwm_out     = (cnt_q < active_q);
  assign duty_active = active_q;
  assign duty_target = target_q;
  assign wr_ready    = (state_q == IDLE);
  assign busy        = (state_q == PEND);
  assign wr_accept   = wr_valid & wr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      active_q <= c_INIT;
      target_q <= c_INIT;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = period_end ? '0 : cnt_q + c_ONE;
    target_d = target_q;
    active_d = active_q;

    // Host write wins; a simultaneous button pulse is dropped, not queued.
    if (wr_accept) begin
      target_d = (wr_duty > c_PERIOD) ? c_PERIOD : wr_duty;
    end else if (inc_pulse && dec_pulse) begin
      target_d = target_q;
    end else if (inc_pulse) begin
      if (target_q != c_PERIOD) target_d = target_q + c_ONE;
    end else if (dec_pulse) begin
      if (target_q != '0) target_d = target_q - c_ONE;
    end

    // Boundary load uses the target registered before this edge.
    if (period_end) begin
`ifdef PWM_SLEW_EN
      if (active_q < target_q) begin
        active_d = active_q + c_ONE;
      end else if (active_q > target_q) begin
        active_d = active_q - c_ONE;
      end
`else
      active_d = target_q;
`endif
    end

    state_d = (active_d != target_d) ? PEND : IDLE;
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : tb_pwm_duty_scheduler                                            |
// | Purpose : Directed self-checking bench for pwm_duty_scheduler (10/5).      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pwm_duty_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc_pulse = 1'b0;
  logic       dec_pulse = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_duty = 4'd0;
  logic       wr_ready;
  logic       pwm_out;
  logic [3:0] duty_active;
  logic [3:0] duty_target;
  logic       period_end;
  logic       busy;

  int n_pass  = 0;
  int n_total = 0;
  int ph      = 0;  // expected cnt in the current cycle

  pwm_duty_scheduler #(.PERIOD(10), .INIT_DUTY(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .wr_valid   (wr_valid),
    .wr_duty    (wr_duty),
    .wr_ready   (wr_ready),
    .pwm_out    (pwm_out),
    .duty_active(duty_active),
    .duty_target(duty_target),
    .period_end (period_end),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    ph = r ? 0 : ((ph == 9) ? 0 : ph + 1);
  endtask

  task automatic goto_ph(input int target_ph);
    while (ph != target_ph) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_total++; if (duty_active !== 4'd5) $display("FAIL reset_active got %0d exp 5", duty_active); else n_pass++;
    n_total++; if (duty_target !== 4'd5) $display("FAIL reset_target got %0d exp 5", duty_target); else n_pass++;
    n_total++; if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b exp 1", wr_ready); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if (pwm_out !== (i < 5)) $display("FAIL reset_pwm cnt=%0d got %b exp %b", i, pwm_out, (i < 5));
      else n_pass++;
      n_total++;
      if (period_end !== (i == 9)) $display("FAIL reset_period_end cnt=%0d got %b exp %b", i, period_end, (i == 9));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_buttons();
    int exp_d;
    int highs;
    for (int k = 1; k <= 6; k++) begin
      inc_pulse = 1'b1;
      tick();
      inc_pulse = 1'b0;
      exp_d = (5 + k > 10) ? 10 : 5 + k;
      n_total++; if (duty_target !== 4'(exp_d)) $display("FAIL inc_target k=%0d got %0d exp %0d", k, duty_target, exp_d); else n_pass++;
      if (k == 1) begin
        n_total++; if (busy !== 1'b1) $display("FAIL inc_busy got %b exp 1", busy); else n_pass++;
        n_total++; if (wr_ready !== 1'b0) $display("FAIL inc_wr_ready got %b exp 0", wr_ready); else n_pass++;
      end
      repeat (11) tick();
      n_total++; if (duty_active !== 4'(exp_d)) $display("FAIL inc_active k=%0d got %0d exp %0d", k, duty_active, exp_d); else n_pass++;
    end
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      highs += int'(pwm_out);
      tick();
    end
    n_total++; if (highs != 10) $display("FAIL full_duty_highs got %0d exp 10", highs); else n_pass++;

    for (int k = 1; k <= 12; k++) begin
      dec_pulse = 1'b1;
      tick();
      dec_pulse = 1'b0;
      exp_d = (10 - k < 0) ? 0 : 10 - k;
      n_total++; if (duty_target !== 4'(exp_d)) $display("FAIL dec_target k=%0d got %0d exp %0d", k, duty_target, exp_d); else n_pass++;
      repeat (11) tick();
      n_total++; if (duty_active !== 4'(exp_d)) $display("FAIL dec_active k=%0d got %0d exp %0d", k, duty_active, exp_d); else n_pass++;
    end
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      highs += int'(pwm_out);
      tick();
    end
    n_total++; if (highs != 0) $display("FAIL zero_duty_highs got %0d exp 0", highs); else n_pass++;
  endtask

  task automatic test_host_write();
    goto_ph(3);
    wr_valid = 1'b1;
    wr_duty  = 4'd15;
    tick();
    n_total++; if (duty_target !== 4'd10) $display("FAIL wr_clamp_target got %0d exp 10", duty_target); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL wr_busy got %b exp 1", busy); else n_pass++;
    n_total++; if (wr_ready !== 1'b0) $display("FAIL wr_ready_drop got %b exp 0", wr_ready); else n_pass++;
    n_total++; if (duty_active !== 4'd0) $display("FAIL wr_active_early got %0d exp 0", duty_active); else n_pass++;
    wr_duty = 4'd2;
    tick();
    wr_valid = 1'b0;
    n_total++; if (duty_target !== 4'd10) $display("FAIL wr_pend_reject got %0d exp 10", duty_target); else n_pass++;
    goto_ph(9);
    n_total++; if (duty_active !== 4'd0) $display("FAIL wr_active_pre got %0d exp 0", duty_active); else n_pass++;
    tick();
    n_total++; if (duty_active !== 4'd10) $display("FAIL wr_active_post got %0d exp 10", duty_active); else n_pass++;
    n_total++; if (busy !== 1'b0 || wr_ready !== 1'b1) $display("FAIL wr_idle_again got busy=%b rdy=%b exp 0/1", busy, wr_ready); else n_pass++;
  endtask

  task automatic test_arbitration();
    wr_valid = 1'b1;
    wr_duty  = 4'd6;
    tick();
    wr_valid = 1'b0;
    goto_ph(9);
    tick();
    n_total++; if (duty_active !== 4'd6) $display("FAIL arb_setup got %0d exp 6", duty_active); else n_pass++;
    inc_pulse = 1'b1;
    dec_pulse = 1'b1;
    tick();
    dec_pulse = 1'b0;
    n_total++; if (duty_target !== 4'd6 || busy !== 1'b0) $display("FAIL arb_both got tgt=%0d busy=%b exp 6/0", duty_target, busy); else n_pass++;
    wr_valid = 1'b1;
    wr_duty  = 4'd2;
    tick();
    wr_valid  = 1'b0;
    inc_pulse = 1'b0;
    n_total++; if (duty_target !== 4'd2) $display("FAIL arb_wr_over_inc got %0d exp 2", duty_target); else n_pass++;
    goto_ph(9);
    tick();
    n_total++; if (duty_active !== 4'd2) $display("FAIL arb_active got %0d exp 2", duty_active); else n_pass++;
    wr_valid = 1'b1;
    wr_duty  = 4'd2;
    tick();
    wr_valid = 1'b0;
    n_total++; if (wr_ready !== 1'b1 || busy !== 1'b0) $display("FAIL wr_equal got rdy=%b busy=%b exp 1/0", wr_ready, busy); else n_pass++;
  endtask

  task automatic test_period_end_request();
    goto_ph(9);
    n_total++; if (period_end !== 1'b1) $display("FAIL pe_flag got %b exp 1", period_end); else n_pass++;
    inc_pulse = 1'b1;
    tick();
    inc_pulse = 1'b0;
    n_total++; if (duty_target !== 4'd3 || duty_active !== 4'd2) $display("FAIL pe_deferred got tgt=%0d act=%0d exp 3/2", duty_target, duty_active); else n_pass++;
    goto_ph(9);
    tick();
    n_total++; if (duty_active !== 4'd3) $display("FAIL pe_applied got %0d exp 3", duty_active); else n_pass++;
  endtask

  task automatic test_reset_pending();
    goto_ph(4);
    wr_valid = 1'b1;
    wr_duty  = 4'd8;
    tick();
    wr_valid = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL rstp_busy got %b exp 1", busy); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++; if (duty_active !== 4'd5 || duty_target !== 4'd5) $display("FAIL rstp_duty got act=%0d tgt=%0d exp 5/5", duty_active, duty_target); else n_pass++;
    n_total++; if (busy !== 1'b0 || wr_ready !== 1'b1) $display("FAIL rstp_state got busy=%b rdy=%b exp 0/1", busy, wr_ready); else n_pass++;
    n_total++; if (pwm_out !== 1'b1 || period_end !== 1'b0) $display("FAIL rstp_cnt0 got pwm=%b pe=%b exp 1/0", pwm_out, period_end); else n_pass++;
    repeat (4) tick();
    n_total++; if (pwm_out !== 1'b1) $display("FAIL rstp_cnt4 got %b exp 1", pwm_out); else n_pass++;
    tick();
    n_total++; if (pwm_out !== 1'b0) $display("FAIL rstp_cnt5 got %b exp 0", pwm_out); else n_pass++;
  endtask

  task automatic test_slew();
    int exp_a;
    wr_valid = 1'b1;
    wr_duty  = 4'd9;
    tick();
    wr_valid = 1'b0;
    n_total++; if (duty_target !== 4'd9) $display("FAIL slew_target got %0d exp 9", duty_target); else n_pass++;
    for (int s = 1; s <= 4; s++) begin
      goto_ph(9);
      tick();
`ifdef PWM_SLEW_EN
      exp_a = 5 + s;
`else
      exp_a = 9;
`endif
      n_total++; if (duty_active !== 4'(exp_a)) $display("FAIL slew_active step=%0d got %0d exp %0d", s, duty_active, exp_a); else n_pass++;
      n_total++; if (busy !== (exp_a != 9)) $display("FAIL slew_busy step=%0d got %b exp %b", s, busy, (exp_a != 9)); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_buttons();
    test_host_write();
    test_arbitration();
    test_period_end_request();
    test_reset_pending();
    test_slew();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
